// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receiver state encoding.
package uart_pkg;
    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 100;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_ready,
    output logic                 rx_err,
    output logic                 rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_s;
    uart_rx_state_t state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
    logic ready_q, ready_d, err_q, err_d, busy_q, busy_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .nRst(nRst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                    busy_d    = !rx_s;
                end
            end
            DATA: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                end
            end
            default: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == FULL_M1) begin
                    // Leave at mid-stop-bit so a following start edge is never missed.
                    clk_cnt_d = '0;
                    byte_d    = rx_s ? shift_q : byte_q;
                    ready_d   = rx_s;
                    err_d     = !rx_s;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_ready = ready_q;
    assign rx_err   = err_q;
    assign rx_busy  = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 100 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 100;

    logic clk = 1'b0;
    logic nRst;
    logic rx_serial;
    logic [7:0] rx_byte;
    logic rx_ready, rx_err, rx_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_cnt = 0, err_cnt = 0, busy_cyc = 0, both_cnt = 0;
    int last_ready_cyc = 0, start_cyc = 0;
    logic [7:0] rxq[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .rx_serial(rx_serial),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .rx_err   (rx_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nRst) begin
            if (rx_ready) begin
                ready_cnt      = ready_cnt + 1;
                last_ready_cyc = cyc;
                rxq.push_back(rx_byte);
            end
            if (rx_err) err_cnt = err_cnt + 1;
            if (rx_busy) busy_cyc = busy_cyc + 1;
            if (rx_ready && rx_err) both_cnt = both_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx_serial = 1'b1;
    endtask

    int r0, e0, b0, q0, lat;
    logic [7:0] c3;

    initial begin
        nRst = 1'b0;
        rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_byte", 32'(rx_byte), 32'h00);
        chk("rst_ready", 32'(rx_ready), 32'h0);
        chk("rst_err", 32'(rx_err), 32'h0);
        chk("rst_busy", 32'(rx_busy), 32'h0);
        nRst = 1'b1;
        repeat (2000) @(negedge clk);
        chk("idle_ready_pulses", 32'(ready_cnt), 32'd0);
        chk("idle_err_pulses", 32'(err_cnt), 32'd0);
        chk("idle_busy_cycles", 32'(busy_cyc), 32'd0);

        send_byte(8'hAB, 1'b1);
        repeat (200) @(negedge clk);
        lat = last_ready_cyc - start_cyc;
        chk("ab_count", 32'(ready_cnt), 32'd1);
        chk("ab_byte", 32'(rx_byte), 32'hAB);
        chk("ab_err", 32'(err_cnt), 32'd0);
        chk("ab_latency_window", 32'(lat >= 951 && lat <= 955), 32'd1);
        chk("ab_busy_low_after", 32'(rx_busy), 32'h0);
        chk("ab_busy_len_window", 32'(busy_cyc >= 895 && busy_cyc <= 905), 32'd1);

        r0 = ready_cnt;
        e0 = err_cnt;
        q0 = rxq.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (200) @(negedge clk);
        chk("b2b_count", 32'(ready_cnt - r0), 32'd3);
        chk("b2b_byte0", 32'(rxq[q0]), 32'h00);
        chk("b2b_byte1", 32'(rxq[q0 + 1]), 32'hFF);
        chk("b2b_byte2", 32'(rxq[q0 + 2]), 32'h55);
        chk("b2b_err", 32'(err_cnt - e0), 32'd0);

        r0 = ready_cnt;
        e0 = err_cnt;
        b0 = busy_cyc;
        rx_serial = 1'b0;
        repeat (30) @(negedge clk);
        rx_serial = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_busy", 32'(busy_cyc - b0), 32'd0);
        chk("glitch_ready", 32'(ready_cnt - r0), 32'd0);
        chk("glitch_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h3C, 1'b1);
        repeat (200) @(negedge clk);
        chk("post_glitch_count", 32'(ready_cnt - r0), 32'd1);
        chk("post_glitch_byte", 32'(rx_byte), 32'h3C);

        r0 = ready_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        repeat (300) @(negedge clk);
        chk("ferr_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("ferr_ready", 32'(ready_cnt - r0), 32'd0);
        chk("ferr_byte_kept", 32'(rx_byte), 32'h3C);
        chk("ferr_busy_low", 32'(rx_busy), 32'h0);

        r0 = ready_cnt;
        e0 = err_cnt;
        c3 = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        chk("mid_busy", 32'(rx_busy), 32'h1);
        nRst = 1'b0;
        #1;
        chk("mid_rst_byte", 32'(rx_byte), 32'h00);
        chk("mid_rst_busy", 32'(rx_busy), 32'h0);
        chk("mid_rst_ready", 32'(rx_ready), 32'h0);
        chk("mid_rst_err", 32'(rx_err), 32'h0);
        rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (300) @(negedge clk);
        chk("mid_rst_no_ready", 32'(ready_cnt - r0), 32'd0);
        chk("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h81, 1'b1);
        repeat (200) @(negedge clk);
        chk("post_rst_count", 32'(ready_cnt - r0), 32'd1);
        chk("post_rst_byte", 32'(rx_byte), 32'h81);
        chk("never_both", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
